// File: rtl/collision_pkg.sv
// Shared types and map geometry for the collision probe scheduler.
package collision_pkg;

    localparam int unsigned TILES_X    = 64;
    localparam int unsigned TILES_Y    = 48;
    localparam int unsigned TILE_SHIFT = 4;
    localparam int unsigned NUM_PROBES = 5;

    typedef enum logic [1:0] {
        TileEmpty = 2'b00,
        TileSolid = 2'b01
    } tile_code_e;

    typedef enum logic [2:0] {
        ProbeL  = 3'd0,
        ProbeR  = 3'd1,
        ProbeLb = 3'd2,
        ProbeRb = 3'd3,
        ProbeA  = 3'd4
    } probe_id_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } sched_state_e;

endpackage

// File: rtl/collision_probe_sched_calc.sv
// Probe geometry: maps a latched position and probe id to a ROM address and OOB flag.
module collision_probe_sched_calc
    import collision_pkg::*;
#(
    parameter int unsigned REC_WIDTH  = 47,
    parameter int unsigned REC_HEIGHT = 63
) (
    input  logic [11:0] px,
    input  logic [11:0] py,
    input  probe_id_e   probe,
    output logic [11:0] addr,
    output logic        oob
);

    localparam logic signed [12:0] TilesXS = 13'(TILES_X);
    localparam logic signed [12:0] TilesYS = 13'(TILES_Y);

    logic signed [12:0] dx, dy;
    logic signed [12:0] x, y;
    logic signed [12:0] tx, ty;

    always_comb begin
        dx = '0;
        dy = '0;
        case (probe)
            ProbeL: begin
                dx = -13'sd1;
                dy = 13'(REC_HEIGHT / 2);
            end
            ProbeR: begin
                dx = 13'(REC_WIDTH);
                dy = 13'(REC_HEIGHT / 2);
            end
            ProbeLb: begin
                dx = '0;
                dy = 13'(REC_HEIGHT + 1);
            end
            ProbeRb: begin
                dx = 13'(REC_WIDTH - 1);
                dy = 13'(REC_HEIGHT + 1);
            end
            ProbeA: begin
                dx = '0;
                dy = -13'sd1;
            end
            default: begin
                dx = '0;
                dy = '0;
            end
        endcase

        x  = $signed({1'b0, px}) + dx;
        y  = $signed({1'b0, py}) + dy;
        // Arithmetic shift keeps negative pixels negative in tile space.
        tx = x >>> TILE_SHIFT;
        ty = y >>> TILE_SHIFT;

        oob  = tx[12] | ty[12] | (tx >= TilesXS) | (ty >= TilesYS);
        addr = oob ? '0 : 12'(ty * TilesXS + tx);
    end

endmodule

// File: rtl/collision_probe_sched.sv
// Serialises the five player collision probes through a single synchronous-read ROM port.
module collision_probe_sched
    import collision_pkg::*;
#(
    parameter int unsigned REC_WIDTH  = 47,
    parameter int unsigned REC_HEIGHT = 63,
    parameter logic [1:0]  OOB_CODE   = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        probe_start,
    input  logic [11:0] pos_x,
    input  logic [11:0] pos_y,
    output logic [11:0] rom_addr,
    input  logic [1:0]  rom_data,
    output logic        busy,
    output logic        result_valid,
    output logic [1:0]  tile_l,
    output logic [1:0]  tile_r,
    output logic [1:0]  tile_lb,
    output logic [1:0]  tile_rb,
    output logic [1:0]  tile_above
);

    sched_state_e state_q, state_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [11:0]  px_q, py_q;
    logic         prev_oob_q;
    logic [1:0]   hold_q [4];
    logic         busy_q, result_valid_q;
    logic [1:0]   tile_l_q, tile_r_q, tile_lb_q, tile_rb_q, tile_above_q;

    probe_id_e    cur_probe;
    logic [11:0]  calc_addr;
    logic         calc_oob;
    logic         capture;
    logic [1:0]   cap_idx;
    logic [1:0]   cap_code;

    assign cur_probe = probe_id_e'(cnt_q);

    collision_probe_sched_calc #(
        .REC_WIDTH  (REC_WIDTH),
        .REC_HEIGHT (REC_HEIGHT)
    ) u_calc (
        .px    (px_q),
        .py    (py_q),
        .probe (cur_probe),
        .addr  (calc_addr),
        .oob   (calc_oob)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        capture  = 1'b0;
        // cnt 1..4 wraps onto hold slots 0..3
        cap_idx  = cnt_q[1:0] - 2'd1;
        rom_addr = '0;
        cap_code = prev_oob_q ? OOB_CODE : rom_data;

        case (state_q)
            StIdle: begin
                if (probe_start) begin
                    state_d = StIssue;
                    cnt_d   = '0;
                end
            end
            StIssue: begin
                rom_addr = calc_addr;
                capture  = (cnt_q != 3'd0);
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'(NUM_PROBES - 1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            px_q           <= '0;
            py_q           <= '0;
            prev_oob_q     <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            tile_l_q       <= TileEmpty;
            tile_r_q       <= TileEmpty;
            tile_lb_q      <= TileEmpty;
            tile_rb_q      <= TileEmpty;
            tile_above_q   <= TileEmpty;
            for (int i = 0; i < 4; i++) begin
                hold_q[i] <= TileEmpty;
            end
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            busy_q         <= (state_d != StIdle);
            result_valid_q <= (state_q == StDrain);

            if (state_q == StIdle && probe_start) begin
                px_q <= pos_x;
                py_q <= pos_y;
            end

            // OOB flag travels alongside the ROM's one-cycle read latency.
            if (state_q == StIssue) begin
                prev_oob_q <= calc_oob;
            end

            if (capture) begin
                hold_q[cap_idx] <= cap_code;
            end

            // Probe 4 arrives this edge, so it bypasses the hold registers.
            if (state_q == StDrain) begin
                tile_l_q     <= hold_q[0];
                tile_r_q     <= hold_q[1];
                tile_lb_q    <= hold_q[2];
                tile_rb_q    <= hold_q[3];
                tile_above_q <= cap_code;
            end
        end
    end

    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign tile_l       = tile_l_q;
    assign tile_r       = tile_r_q;
    assign tile_lb      = tile_lb_q;
    assign tile_rb      = tile_rb_q;
    assign tile_above   = tile_above_q;

endmodule

// File: tb/tb_collision_probe_sched.sv
// Scoreboard bench for collision_probe_sched with a one-cycle-latency ROM model.
module tb_collision_probe_sched;

    logic        clk;
    logic        rst;
    logic        probe_start;
    logic [11:0] pos_x, pos_y;
    logic [11:0] rom_addr;
    logic [1:0]  rom_data;
    logic        busy, result_valid;
    logic [1:0]  tile_l, tile_r, tile_lb, tile_rb, tile_above;

    logic [1:0]  rom_mem [3072];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int bcnt    = 0;

    logic [11:0] exp_addr_q [$];
    logic [9:0]  exp_tile_q [$];
    int          rv_cyc_q   [$];

    collision_probe_sched dut (
        .clk          (clk),
        .rst          (rst),
        .probe_start  (probe_start),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .busy         (busy),
        .result_valid (result_valid),
        .tile_l       (tile_l),
        .tile_r       (tile_r),
        .tile_lb      (tile_lb),
        .tile_rb      (tile_rb),
        .tile_above   (tile_above)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: addresses during the first five busy cycles, tiles on result_valid.
    always @(negedge clk) begin
        logic [9:0] et;
        if (busy) begin
            if (bcnt < 5) begin
                if (exp_addr_q.size() == 0) begin
                    check("addr_unexpected", {20'd0, rom_addr}, 32'hFFFF);
                end else begin
                    check($sformatf("rom_addr_c%0d", bcnt + 1), {20'd0, rom_addr},
                          {20'd0, exp_addr_q.pop_front()});
                end
            end
            bcnt++;
        end else begin
            bcnt = 0;
        end
        if (result_valid) begin
            rv_cyc_q.push_back(cyc);
            check("rv_cycle", bcnt, 7);
            if (exp_tile_q.size() == 0) begin
                check("rv_unexpected", 1, 0);
            end else begin
                et = exp_tile_q.pop_front();
                check("tile_l",     {30'd0, tile_l},     {30'd0, et[9:8]});
                check("tile_r",     {30'd0, tile_r},     {30'd0, et[7:6]});
                check("tile_lb",    {30'd0, tile_lb},    {30'd0, et[5:4]});
                check("tile_rb",    {30'd0, tile_rb},    {30'd0, et[3:2]});
                check("tile_above", {30'd0, tile_above}, {30'd0, et[1:0]});
            end
        end
        cyc++;
    end

    task automatic push_exp(input logic [59:0] addrs, input int n_addr, input logic [9:0] tiles,
                            input bit want_result);
        for (int i = 0; i < n_addr; i++) begin
            exp_addr_q.push_back(addrs[59 - 12 * i -: 12]);
        end
        if (want_result) exp_tile_q.push_back(tiles);
    endtask

    // Returns 1 time unit after the sampling edge E0, i.e. at the start of cycle 1.
    task automatic pulse_start(input logic [11:0] x, input logic [11:0] y);
        @(posedge clk);
        #1;
        pos_x       = x;
        pos_y       = y;
        probe_start = 1'b1;
        @(posedge clk);
        #1;
        probe_start = 1'b0;
    endtask

    // Expected vectors: {a0..a4} and {l, r, lb, rb, above}
    localparam logic [59:0] AddrMid = {12'd1667, 12'd1670, 12'd1859, 12'd1862, 12'd1539};
    localparam logic [9:0]  TileMid = {2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
    localparam logic [59:0] AddrTl  = {12'd0, 12'd66, 12'd256, 12'd258, 12'd0};
    localparam logic [9:0]  TileTl  = {2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    localparam logic [59:0] AddrBot = {12'd2947, 12'd2950, 12'd0, 12'd0, 12'd2819};
    localparam logic [9:0]  TileBot = {2'd3, 2'd2, 2'd1, 2'd1, 2'd1};

    initial begin
        for (int i = 0; i < 3072; i++) rom_mem[i] = 2'b00;
        rom_mem[1667] = 2'd1;
        rom_mem[1670] = 2'd2;
        rom_mem[1859] = 2'd3;
        rom_mem[1862] = 2'd1;
        rom_mem[1539] = 2'd2;
        rom_mem[66]   = 2'd2;
        rom_mem[256]  = 2'd3;
        rom_mem[2947] = 2'd3;
        rom_mem[2950] = 2'd2;
        rom_mem[2819] = 2'd1;

        rst         = 1'b1;
        probe_start = 1'b0;
        pos_x       = '0;
        pos_y       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_rv", {31'd0, result_valid}, 0);
        check("reset_addr", {20'd0, rom_addr}, 0);
        check("reset_tiles", {22'd0, tile_l, tile_r, tile_lb, tile_rb, tile_above}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // In-bounds run
        push_exp(AddrMid, 5, TileMid, 1'b1);
        pulse_start(12'd50, 12'd400);
        repeat (10) @(posedge clk);

        // Left/top edge
        push_exp(AddrTl, 5, TileTl, 1'b1);
        pulse_start(12'd0, 12'd0);
        repeat (10) @(posedge clk);

        // Bottom edge
        push_exp(AddrBot, 5, TileBot, 1'b1);
        pulse_start(12'd50, 12'd720);
        repeat (10) @(posedge clk);

        // Start held high: samples at E0, E8, E16 only
        rv_cyc_q.delete();
        for (int i = 0; i < 3; i++) push_exp(AddrMid, 5, TileMid, 1'b1);
        @(posedge clk);
        #1;
        pos_x       = 12'd50;
        pos_y       = 12'd400;
        probe_start = 1'b1;
        repeat (17) @(posedge clk);
        #1 probe_start = 1'b0;
        repeat (12) @(posedge clk);
        check("held_rv_count", rv_cyc_q.size(), 3);
        if (rv_cyc_q.size() == 3) begin
            check("held_period_0", rv_cyc_q[1] - rv_cyc_q[0], 8);
            check("held_period_1", rv_cyc_q[2] - rv_cyc_q[1], 8);
        end

        // Position changes mid-run must not leak in
        push_exp(AddrMid, 5, TileMid, 1'b1);
        pulse_start(12'd50, 12'd400);
        repeat (2) @(posedge clk);
        #1;
        pos_x = 12'd200;
        pos_y = 12'd200;
        repeat (10) @(posedge clk);

        // Reset in cycle 4 aborts; only probes 0..3 get presented
        push_exp(AddrBot, 4, '0, 1'b0);
        pulse_start(12'd50, 12'd720);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_tiles", {22'd0, tile_l, tile_r, tile_lb, tile_rb, tile_above}, 0);

        // Fresh run after abort
        push_exp(AddrTl, 5, TileTl, 1'b1);
        pulse_start(12'd0, 12'd0);
        repeat (12) @(posedge clk);

        @(negedge clk);
        check("addr_queue_drained", exp_addr_q.size(), 0);
        check("tile_queue_drained", exp_tile_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
